mem_port_arbiter: RTL and testbench

- Arbitrates one shared single-ported memory bus between two requesters: instruction fetch (I) and data load/store (D).
- Sits between the IF/MEM stages and the unified memory interface.
- Drives the `grant` select that steers the 2:1 address/data muxes in front of memory.
- Data side has priority; a streak counter bounds how long instruction fetch can be starved.

---
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 tb/tb_mem_port_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Purpose: two-way arbiter sharing one single-ported memory bus between
//          instruction fetch (I) and data load/store (D); D has priority,
//          a saturating streak counter bounds how long I can be starved.
// Ports:   clk/rst (sync, active-high); I side: i_req/i_addr -> i_ack/i_rdata;
//          D side: d_req/d_we/d_addr/d_wdata -> d_ack/d_rdata;
//          memory side: mem_req/mem_we/mem_addr/mem_wdata <- mem_ack/mem_rdata;
//          grant steers the external address/data muxes (0 = I, 1 = D).
// Timing:  all outputs registered; minimum 3 cycles per transfer
//          (IDLE arbitrate, ISSUE wait for mem_ack, RESP ack pulse).
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              grant
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state;
    logic [3:0] streak;
    logic       pick_d;

    // D wins unless I is waiting and D has already had LIMIT grants in a row.
    always_comb begin
        pick_d = d_req && (!i_req || (streak < LIMIT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            streak    <= 4'd0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            grant     <= 1'b0;
        end else begin
            // Acks are single-cycle pulses raised only on the ISSUE->RESP edge.
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_req || i_req) begin
                        mem_req <= 1'b1;
                        state   <= ISSUE;
                        if (pick_d) begin
                            grant     <= 1'b1;
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            // Count only D grants that actually made I wait.
                            if (i_req) begin
                                streak <= (streak == 4'hF) ? streak : streak + 4'd1;
                            end else begin
                                streak <= 4'd0;
                            end
                        end else begin
                            grant     <= 1'b0;
                            mem_we    <= 1'b0;
                            mem_addr  <= i_addr;
                            mem_wdata <= '0;
                            streak    <= 4'd0;
                        end
                    end
                end
                ISSUE: begin
                    // Bus held stable; requester inputs ignored until completion.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= RESP;
                        if (grant) begin
                            d_rdata <= mem_rdata;
                            d_ack   <= 1'b1;
                        end else begin
                            i_rdata <= mem_rdata;
                            i_ack   <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    // No re-grant here, so a just-completed request is never served twice.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs driven and outputs sampled on the
// falling clock edge, one task per scenario with inline expected values.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, d_req, d_we, mem_ack;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic          i_ack, d_ack, mem_req, mem_we, grant;
    logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_i, exp_d;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .grant(grant)
    );

    // Waits (bounded) for mem_req to be seen on a falling edge.
    task automatic wait_mem_req(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; i_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        checks++; if ({mem_req, mem_we, grant, i_ack, d_ack} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 00000", {mem_req, mem_we, grant, i_ack, d_ack}); end
        checks++; if (mem_addr !== '0 || mem_wdata !== '0) begin errors++; $display("FAIL reset_bus: got addr=%h wdata=%h want 0", mem_addr, mem_wdata); end
        checks++; if (i_rdata !== '0 || d_rdata !== '0) begin errors++; $display("FAIL reset_rdata: got i=%h d=%h want 0", i_rdata, d_rdata); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_fetch();
        i_req = 1; i_addr = 32'h100;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || grant !== 1'b0) begin errors++; $display("FAIL fetch_ctrl: got req=%b we=%b grant=%b want 1 0 0", mem_req, mem_we, grant); end
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL fetch_addr: got %h want 00000100", mem_addr); end
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || i_ack !== 1'b0) begin errors++; $display("FAIL fetch_hold: got req=%b i_ack=%b want 1 0", mem_req, i_ack); end
        mem_ack = 1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        mem_ack = 0; i_req = 0;
        checks++; if (i_ack !== 1'b1 || d_ack !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL fetch_ack: got i_ack=%b d_ack=%b req=%b want 1 0 0", i_ack, d_ack, mem_req); end
        checks++; if (i_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_rdata: got %h want deadbeef", i_rdata); end
        exp_i = 32'hDEADBEEF;
        @(negedge clk);
        checks++; if (i_ack !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL fetch_pulse: got i_ack=%b req=%b want 0 0", i_ack, mem_req); end
    endtask

    task automatic test_store();
        d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'h12345678;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || grant !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== 32'h12345678 || d_ack !== 1'b0)
                begin errors++; $display("FAIL store_hold[%0d]: got req=%b we=%b g=%b addr=%h wdata=%h d_ack=%b", c, mem_req, mem_we, grant, mem_addr, mem_wdata, d_ack); end
        end
        mem_ack = 1; mem_rdata = 32'hCAFE0000;
        @(negedge clk);
        mem_ack = 0; d_req = 0; d_we = 0;
        checks++; if (d_ack !== 1'b1 || i_ack !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL store_ack: got d_ack=%b i_ack=%b req=%b want 1 0 0", d_ack, i_ack, mem_req); end
        exp_d = 32'hCAFE0000;
        @(negedge clk);
        checks++; if (d_ack !== 1'b0 || i_rdata !== exp_i) begin errors++; $display("FAIL store_pulse: got d_ack=%b i_rdata=%h want 0 %h", d_ack, i_rdata, exp_i); end
    endtask

    task automatic test_simultaneous();
        i_req = 1; i_addr = 32'h300; d_req = 1; d_we = 0; d_addr = 32'h400;
        @(negedge clk);
        checks++; if (grant !== 1'b1 || mem_addr !== 32'h400 || mem_we !== 1'b0) begin errors++; $display("FAIL simul_first: got grant=%b addr=%h we=%b want 1 400 0", grant, mem_addr, mem_we); end
        mem_ack = 1; mem_rdata = 32'h11111111;
        @(negedge clk);
        mem_ack = 0; d_req = 0;
        checks++; if (d_ack !== 1'b1 || i_ack !== 1'b0 || d_rdata !== 32'h11111111) begin errors++; $display("FAIL simul_dack: got d_ack=%b i_ack=%b d_rdata=%h", d_ack, i_ack, d_rdata); end
        exp_d = 32'h11111111;
        @(negedge clk);
        checks++; if (mem_req !== 1'b0 || d_ack !== 1'b0) begin errors++; $display("FAIL simul_idle: got req=%b d_ack=%b want 0 0", mem_req, d_ack); end
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || grant !== 1'b0 || mem_addr !== 32'h300) begin errors++; $display("FAIL simul_second: got req=%b grant=%b addr=%h want 1 0 300", mem_req, grant, mem_addr); end
        mem_ack = 1; mem_rdata = 32'h22222222;
        @(negedge clk);
        mem_ack = 0; i_req = 0;
        checks++; if (i_ack !== 1'b1 || d_ack !== 1'b0 || i_rdata !== 32'h22222222) begin errors++; $display("FAIL simul_iack: got i_ack=%b d_ack=%b i_rdata=%h", i_ack, d_ack, i_rdata); end
        exp_i = 32'h22222222;
        @(negedge clk);
    endtask

    task automatic test_starvation();
        bit ok;
        bit exp_g [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        i_req = 1; i_addr = 32'h600; d_req = 1; d_we = 0; d_addr = 32'h700;
        for (int k = 0; k < 10; k++) begin
            wait_mem_req(ok);
            checks++; if (!ok) begin errors++; $display("FAIL starve_timeout[%0d]: got no mem_req want mem_req=1", k); break; end
            checks++; if (grant !== exp_g[k]) begin errors++; $display("FAIL starve_grant[%0d]: got %b want %b", k, grant, exp_g[k]); end
            mem_ack = 1; mem_rdata = 32'h5000_0000 + k;
            if (exp_g[k]) exp_d = 32'h5000_0000 + k; else exp_i = 32'h5000_0000 + k;
            @(negedge clk);
            mem_ack = 0;
            if (k == 9) begin i_req = 0; d_req = 0; end
            checks++; if (i_ack !== !exp_g[k] || d_ack !== exp_g[k]) begin errors++; $display("FAIL starve_ack[%0d]: got i_ack=%b d_ack=%b want %b %b", k, i_ack, d_ack, !exp_g[k], exp_g[k]); end
        end
        @(negedge clk);
        checks++; if (i_rdata !== exp_i || d_rdata !== exp_d) begin errors++; $display("FAIL starve_rdata: got i=%h d=%h want %h %h", i_rdata, d_rdata, exp_i, exp_d); end
    endtask

    task automatic test_spurious_ack();
        @(negedge clk);
        mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if (mem_req !== 1'b0 || i_ack !== 1'b0 || d_ack !== 1'b0 || i_rdata !== exp_i || d_rdata !== exp_d)
                begin errors++; $display("FAIL spurious[%0d]: got req=%b i_ack=%b d_ack=%b i=%h d=%h want 0 0 0 %h %h", c, mem_req, i_ack, d_ack, i_rdata, d_rdata, exp_i, exp_d); end
        end
        mem_ack = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_issue();
        d_req = 1; d_we = 1; d_addr = 32'h500; d_wdata = 32'hAAAA5555;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || grant !== 1'b1) begin errors++; $display("FAIL rst_issue_pre: got req=%b grant=%b want 1 1", mem_req, grant); end
        rst = 1; d_req = 0; d_we = 0;
        @(negedge clk);
        rst = 0;
        checks++; if ({mem_req, mem_we, grant, i_ack, d_ack} !== 5'b0 || mem_addr !== '0 || mem_wdata !== '0 || i_rdata !== '0 || d_rdata !== '0)
            begin errors++; $display("FAIL rst_issue_clear: got ctrl=%b addr=%h wdata=%h i=%h d=%h want all 0", {mem_req, mem_we, grant, i_ack, d_ack}, mem_addr, mem_wdata, i_rdata, d_rdata); end
        mem_ack = 1; mem_rdata = 32'hBBBBBBBB;
        @(negedge clk);
        mem_ack = 0;
        for (int c = 0; c < 2; c++) begin
            checks++; if (i_ack !== 1'b0 || d_ack !== 1'b0 || mem_req !== 1'b0 || d_rdata !== '0)
                begin errors++; $display("FAIL rst_late_ack[%0d]: got i_ack=%b d_ack=%b req=%b d_rdata=%h want 0 0 0 0", c, i_ack, d_ack, mem_req, d_rdata); end
            @(negedge clk);
        end
    endtask

    initial begin
        exp_i = '0; exp_d = '0;
        test_reset();
        test_single_fetch();
        test_store();
        test_simultaneous();
        test_starvation();
        test_spurious_ack();
        test_reset_mid_issue();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
